// File: rtl/frame_reader.sv
// frame_reader: raster-order frame scanner for BRAM port B with a 2-entry skid FIFO on the pixel stream
module frame_reader #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1,
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1
) (
  input  logic              clkb,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              frame_done
);
  localparam int SW = XW + YW + 3;
  localparam int EW = DATA_W + SW;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [XW-1:0] rx;
  logic [YW-1:0] ry;
  logic [SW-1:0] sh;
  logic [EW-1:0] head, tail, entry;
  logic [1:0] count;
  logic [2:0] occ;
  logic inflight, issue, pop, sof_i, eol_i, eof_i;
  assign pix_valid = count != 2'd0;
  assign {pix_data, pix_x, pix_y, sof, eol, eof} = head;
  assign entry = {doutb, sh};
  // Issue decision: only read when the FIFO slot is guaranteed after accounting for in-flight data and this cycle's pop
  always_comb begin
    pop = pix_valid & pix_ready;
    occ = 3'(count) + 3'(inflight) - 3'(pop);
    issue = state == ISSUE && occ < 3'd2;
    eol_i = rx == XW'(WIDTH - 1);
    sof_i = rx == '0 && ry == '0;
    eof_i = eol_i && ry == YW'(HEIGHT - 1);
  end
  // Scan FSM: address/raster counters, in-flight flag and sideband shadow for the outstanding read
  always_ff @(posedge clkb or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      addrb <= '0;
      rx <= '0;
      ry <= '0;
      inflight <= 1'b0;
      sh <= '0;
    end else begin
      inflight <= issue;
      frame_done <= 1'b0;
      if (state == IDLE && start) begin
        state <= ISSUE;
        busy <= 1'b1;
        addrb <= '0;
        rx <= '0;
        ry <= '0;
      end
      if (issue) begin
        sh <= {rx, ry, sof_i, eol_i, eof_i};
        addrb <= addrb == LAST ? addrb : addrb + 1'b1;
        rx <= eol_i ? '0 : rx + 1'b1;
        if (eol_i) ry <= ry == YW'(HEIGHT - 1) ? '0 : ry + 1'b1;
        if (addrb == LAST) state <= DRAIN;
      end
      if (state == DRAIN && pop && eof) begin
        state <= IDLE;
        busy <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  // Skid FIFO: head feeds the stream and only moves on pop or when filling an empty FIFO
  always_ff @(posedge clkb or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (pop && count == 2'd2) head <= tail;
      else if (inflight && (count == 2'd0 || (pop && count == 2'd1))) head <= entry;
      if (inflight && ((count == 2'd1 && !pop) || count == 2'd2)) tail <= entry;
      count <= count + 2'(inflight) - 2'(pop);
    end
  // Occupancy can never exceed two entries given the issue rule
  always @(posedge clkb)
    if (!rst) assert (count != 2'd3);
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader on a 4x3 frame plus a full 160x120 frame
module tb_frame_reader;
  localparam int W = 4, H = 3, N = W * H;
  localparam int BW = 160, BH = 120, BN = BW * BH;
  logic clk = 0, rst = 0, s_start = 0, b_start = 0, s_ready = 0;
  logic [14:0] s_addr, b_addr;
  logic [7:0] s_dout = 0, b_dout = 0, s_data, b_data;
  logic [1:0] s_x, s_y;
  logic [7:0] b_x;
  logic [6:0] b_y;
  logic s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
  logic b_valid, b_sof, b_eol, b_eof, b_busy, b_done;
  int n_pass = 0, n_chk = 0, cyc = 0, xfers = 0, dones = 0, pushed = 0, bp = 0;
  int first_v = -1, first_x = -1, last_x = -1, fd_cyc = -1, start_cyc = 0;
  bit held = 0;
  logic [14:0] prev = '0;
  logic [14:0] sb[$];
  wire [14:0] cur = {s_data, s_x, s_y, s_sof, s_eol, s_eof};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s_dout <= 8'(s_addr + 15'h10);
    b_dout <= 8'(b_addr + 15'h10);
  end

  frame_reader #(.WIDTH(W), .HEIGHT(H)) u_s (
    .clkb(clk), .rst(rst), .start(s_start), .addrb(s_addr), .doutb(s_dout),
    .pix_data(s_data), .pix_valid(s_valid), .pix_ready(s_ready), .pix_x(s_x), .pix_y(s_y),
    .sof(s_sof), .eol(s_eol), .eof(s_eof), .busy(s_busy), .frame_done(s_done)
  );

  frame_reader u_b (
    .clkb(clk), .rst(rst), .start(b_start), .addrb(b_addr), .doutb(b_dout),
    .pix_data(b_data), .pix_valid(b_valid), .pix_ready(1'b1), .pix_x(b_x), .pix_y(b_y),
    .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy), .frame_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    logic [14:0] e;
    @(negedge clk);
    cyc++;
    s_start = 0;
    s_ready = bp != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
    if (held) chk("hold", 32'(cur), 32'(prev));
    if (u_s.count > 2'd2) chk("fifo_cnt", 32'(u_s.count), 32'd2);
    if (s_valid && first_v < 0) first_v = cyc;
    if (s_valid && s_ready) begin
      if (sb.size() == 0) chk("xfer_vs_sb", 32'(xfers + 1), 32'(pushed));
      else begin
        e = sb.pop_front();
        chk("pix", 32'(cur), 32'(e));
      end
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      xfers++;
    end
    held = s_valid && !s_ready;
    prev = cur;
    if (s_done) begin
      dones++;
      fd_cyc = cyc;
    end
  endtask

  task automatic begin_frame(input int mode);
    xfers = 0; dones = 0; pushed = 0;
    first_v = -1; first_x = -1; last_x = -1; fd_cyc = -1;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      sb.push_back({8'(i + 16), 2'(i % W), 2'(i / W), i == 0, i % W == W - 1, i == N - 1});
      pushed++;
    end
    bp = mode;
    start_cyc = cyc;
    s_start = 1;
  endtask

  task automatic run_frame(input int mode, input int restart_at);
    bit restarted = 0;
    begin_frame(mode);
    tick();
    chk("addr_start", 32'(s_addr), 32'd0);
    for (int t = 0; t < 400 && dones == 0; t++) begin
      tick();
      if (xfers == restart_at && !restarted) begin
        s_start = 1;
        restarted = 1;
      end
    end
    if (dones == 0) chk("frame_timeout", 32'(dones), 32'd1);
    repeat (10) tick();
    chk("xfers", 32'(xfers), 32'(N));
    chk("frame_done_cnt", 32'(dones), 32'd1);
    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("busy_after", 32'(s_busy), 32'd0);
  endtask

  initial begin
    int k, errs;
    #2 rst = 1;
    #1;
    chk("rst_addrb", 32'(s_addr), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_side", 32'(cur), 32'd0);
    chk("rst_busy_done", 32'({s_busy, s_done}), 32'd0);
    chk("rst_b_addrb", 32'(b_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    tick();

    run_frame(0, -1);
    chk("lat", 32'(first_v - start_cyc - 1), 32'd2);
    chk("consecutive", 32'(last_x - first_x), 32'(N - 1));
    chk("fd_delay", 32'(fd_cyc - last_x), 32'd1);

    run_frame(1, -1);
    run_frame(1, 5);

    begin_frame(1);
    for (int t = 0; t < 400 && xfers < 6; t++) tick();
    chk("pre_rst_xfers", 32'(xfers), 32'd6);
    #2 rst = 1;
    #1;
    chk("midrst_valid", 32'(s_valid), 32'd0);
    chk("midrst_addrb", 32'(s_addr), 32'd0);
    chk("midrst_busy", 32'(s_busy), 32'd0);
    chk("midrst_side", 32'(cur), 32'd0);
    @(negedge clk);
    chk("midrst_valid_hold", 32'(s_valid), 32'd0);
    rst = 0;
    held = 0;
    tick();
    run_frame(0, -1);
    chk("restart_lat", 32'(first_v - start_cyc - 1), 32'd2);

    k = 0;
    errs = 0;
    @(negedge clk) b_start = 1;
    @(negedge clk) b_start = 0;
    for (int t = 0; t < BN + 100 && !b_done; t++) begin
      @(negedge clk);
      if (b_valid) begin
        if (b_data != 8'(k + 16)) errs++;
        if (b_eof) begin
          chk("big_eof_x", 32'(b_x), 32'(BW - 1));
          chk("big_eof_y", 32'(b_y), 32'(BH - 1));
          chk("big_eof_idx", 32'(k), 32'(BN - 1));
        end
        k++;
      end
    end
    chk("big_done", 32'(b_done), 32'd1);
    chk("big_xfers", 32'(k), 32'(BN));
    chk("big_last_addr", 32'(b_addr), 32'(BN - 1));
    chk("big_data_errs", 32'(errs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
